// File: rtl/hdb3_pkg.sv
// HDB3 transmit scheduler shared definitions.
// Owner codes, idle fill bytes and FSM state encodings.
package hdb3_pkg;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam logic [7:0] IDLE_AIS  = 8'hFF;
    localparam logic [7:0] IDLE_ZERO = 8'h00;

    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// grant[0] = A, grant[1] = B; all zero when not advancing.
module rr_arb2
    import hdb3_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last_grant,
    input  logic       advance,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (advance) begin
            if (req_a && req_b)
                grant = (last_grant == LAST_B) ? 2'b01 : 2'b10;
            else if (req_a)
                grant = 2'b01;
            else if (req_b)
                grant = 2'b10;
        end
    end

endmodule

// File: rtl/hdb3_tx_sched.sv
// Byte-slot scheduler feeding the HDB3 encoder serial input.
// Arbitrates two byte sources, fills gaps with an idle byte.
module hdb3_tx_sched
    import hdb3_pkg::*;
#(
    parameter int IDLE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  idle_sel,
    input  logic                  a_valid,
    input  logic [7:0]            a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [7:0]            b_data,
    output logic                  b_ready,
    input  logic                  clr_idle_cnt,
    output logic                  tx_bit,
    output logic                  tx_active,
    output logic [1:0]            slot_owner,
    output logic [IDLE_CNT_W-1:0] idle_cnt
);

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       last_grant;
    logic [1:0] grant;
    logic       boundary;
    logic       load;
    logic       idle_load;
    logic [7:0] load_byte;

    assign boundary = (state == ST_STOP && enable)
                   || (state == ST_RUN && bit_cnt == 3'd7);
    // Reset gates the load so ready is never raised while in reset.
    assign load      = boundary & enable & ~reset;
    assign idle_load = load & ~(|grant);

    rr_arb2 u_arb (
        .req_a      (a_valid),
        .req_b      (b_valid),
        .last_grant (last_grant),
        .advance    (load),
        .grant      (grant)
    );

    assign a_ready = grant[0];
    assign b_ready = grant[1];

    always_comb begin
        load_byte = idle_sel ? IDLE_AIS : IDLE_ZERO;
        unique case (1'b1)
            grant[0]: load_byte = a_data;
            grant[1]: load_byte = b_data;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_STOP;
            bit_cnt    <= 3'd7;
            shreg      <= 8'h00;
            slot_owner <= OWN_IDLE;
            last_grant <= LAST_B;
        end else if (load) begin
            state      <= ST_RUN;
            bit_cnt    <= 3'd0;
            shreg      <= load_byte;
            slot_owner <= grant;
            if (|grant)
                last_grant <= grant[1];
        end else if (boundary) begin
            // Slot finished with enable low: park with the line at zero.
            state      <= ST_STOP;
            shreg      <= 8'h00;
            slot_owner <= OWN_IDLE;
        end else if (state == ST_RUN) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            idle_cnt <= '0;
        else if (clr_idle_cnt)
            idle_cnt <= IDLE_CNT_W'(idle_load);
        else if (idle_load && !(&idle_cnt))
            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
    end

    assign tx_bit    = shreg[7];
    assign tx_active = (state == ST_RUN);

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// Self-checking bench for hdb3_tx_sched.
// Table of byte slots plus hand sequences; slot scoreboard queue.
module tb_hdb3_tx_sched;
    import hdb3_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        idle_sel = 1'b0;
    logic        a_valid = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic        b_valid = 1'b0;
    logic [7:0]  b_data = 8'h00;
    logic        clr_idle_cnt = 1'b0;

    logic        a_ready, b_ready, tx_bit, tx_active;
    logic [1:0]  slot_owner;
    logic [15:0] idle_cnt;

    logic        a_ready3, b_ready3, tx_bit3, tx_active3;
    logic [1:0]  slot_owner3;
    logic [2:0]  idle_cnt3;

    int checks = 0;
    int errors = 0;
    int exp_idle = 0;

    typedef struct {
        bit         rst;
        logic       en;
        logic       isel;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic [1:0] owner;
        logic [7:0] byte_v;
    } vec_t;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] byte_v;
    } slot_t;

    slot_t sb[$];
    vec_t  tbl[16];

    hdb3_tx_sched dut (
        .clk(clk), .reset(reset), .enable(enable), .idle_sel(idle_sel),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .clr_idle_cnt(clr_idle_cnt), .tx_bit(tx_bit),
        .tx_active(tx_active), .slot_owner(slot_owner),
        .idle_cnt(idle_cnt)
    );

    hdb3_tx_sched #(.IDLE_CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .idle_sel(idle_sel),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready3),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready3),
        .clr_idle_cnt(clr_idle_cnt), .tx_bit(tx_bit3),
        .tx_active(tx_active3), .slot_owner(slot_owner3),
        .idle_cnt(idle_cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    // Caller is at a negedge; reset is held with live inputs to test override.
    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        @(negedge clk);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_owner", slot_owner, OWN_IDLE);
        chk("rst_idle_cnt", idle_cnt, 0);
        chk("rst_idle_cnt3", idle_cnt3, 0);
        reset = 1'b0; enable = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        exp_idle = 0;
    endtask

    // Drives one slot at the current negedge and checks its 8 bits.
    task automatic run_slot(input vec_t v, input int drop_at,
                            input bit clr_load);
        slot_t s;
        enable = v.en; idle_sel = v.isel;
        a_valid = v.av; a_data = v.ad;
        b_valid = v.bv; b_data = v.bd;
        clr_idle_cnt = clr_load;
        #1;
        chk("a_ready_load", a_ready, (v.owner == OWN_A));
        chk("b_ready_load", b_ready, (v.owner == OWN_B));
        s.owner = v.owner; s.byte_v = v.byte_v;
        sb.push_back(s);
        if (v.owner == OWN_IDLE)
            exp_idle = clr_load ? 1 : exp_idle + 1;
        else if (clr_load)
            exp_idle = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clr_idle_cnt = 1'b0;
            chk("tx_bit", tx_bit, sb[0].byte_v[7-i]);
            chk("slot_owner", slot_owner, sb[0].owner);
            chk("tx_active", tx_active, 1);
            if (i == 0) begin
                chk("idle_cnt", idle_cnt, exp_idle);
                chk("idle_cnt3", idle_cnt3, sat3(exp_idle));
            end
            if (i < 7) begin
                chk("a_ready_mid", a_ready, 0);
                chk("b_ready_mid", b_ready, 0);
            end
            if (i == drop_at)
                enable = 1'b0;
        end
        void'(sb.pop_front());
    endtask

    initial begin
        tbl[0]  = '{0, 1, 1, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'hFF};
        tbl[1]  = '{0, 1, 1, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'hFF};
        tbl[2]  = '{0, 1, 0, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'h00};
        tbl[3]  = '{0, 1, 0, 1, 8'hA5, 0, 8'h00, OWN_A,    8'hA5};
        tbl[4]  = '{0, 1, 1, 1, 8'hA5, 0, 8'h00, OWN_A,    8'hA5};
        tbl[5]  = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_B,    8'hF0};
        tbl[6]  = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_A,    8'h0F};
        tbl[7]  = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_B,    8'hF0};
        tbl[8]  = '{0, 1, 1, 0, 8'h0F, 0, 8'hF0, OWN_IDLE, 8'hFF};
        tbl[9]  = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_A,    8'h0F};
        tbl[10] = '{0, 1, 1, 0, 8'h00, 1, 8'h3C, OWN_B,    8'h3C};
        tbl[11] = '{0, 1, 1, 1, 8'h81, 0, 8'h00, OWN_A,    8'h81};
        tbl[12] = '{1, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_A,    8'h0F};
        tbl[13] = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_B,    8'hF0};
        tbl[14] = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_A,    8'h0F};
        tbl[15] = '{0, 1, 0, 1, 8'h0F, 1, 8'hF0, OWN_B,    8'hF0};

        @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("stop_tx_bit", tx_bit, 0);
        chk("stop_active", tx_active, 0);

        foreach (tbl[k]) begin
            if (tbl[k].rst)
                do_reset();
            run_slot(tbl[k], -1, 1'b0);
        end

        // enable drops at bit_cnt 3 of an A slot
        run_slot('{0, 1, 0, 1, 8'hA5, 0, 8'h00, OWN_A, 8'hA5}, 3, 1'b0);
        #1;
        chk("drop_a_ready", a_ready, 0);
        @(negedge clk);
        chk("drop_tx_bit", tx_bit, 0);
        chk("drop_active", tx_active, 0);
        chk("drop_owner", slot_owner, OWN_IDLE);
        @(negedge clk);
        chk("drop_hold_active", tx_active, 0);

        // reset in the middle of a slot
        enable = 1'b1; a_valid = 1'b1; a_data = 8'hA5;
        repeat (3) @(negedge clk);
        chk("pre_rst_active", tx_active, 1);
        do_reset();

        // idle counter saturation (3-bit) and clear on an idle load
        for (int n = 0; n < 9; n++) begin
            if (n % 2 == 0)
                run_slot('{0, 1, 1, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'hFF},
                         -1, 1'b0);
            else
                run_slot('{0, 1, 0, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'h00},
                         -1, 1'b0);
        end
        chk("sat_idle_cnt", idle_cnt, 9);
        chk("sat_idle_cnt3", idle_cnt3, 7);
        run_slot('{0, 1, 1, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'hFF}, -1, 1'b1);
        run_slot('{0, 1, 0, 0, 8'h00, 0, 8'h00, OWN_IDLE, 8'h00}, -1, 1'b0);
        chk("clr_then_idle", idle_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hdb3_tx_sched.md
HDB3_TX_SCHED -- requirements
Module: hdb3_tx_sched

Interface
REQ-001 Parameter: IDLE_CNT_W, default 16, width of the idle-slot counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run request; 1 = schedule byte slots, 0 = stop at the next slot boundary.
REQ-005 idle_sel  input  1  idle fill byte select; 1 = 8'hFF (AIS), 0 = 8'h00.
REQ-006 a_valid  input  1  requester A byte available.
REQ-007 a_data  input  8  requester A byte.
REQ-008 a_ready  output  1  requester A byte accepted this cycle.
REQ-009 b_valid, b_data, b_ready  in/in/out  1/8/1  requester B; same meaning as A.
REQ-010 clr_idle_cnt  input  1  clear idle_cnt.
REQ-011 tx_bit  output  1  serial bit to the HDB3 encoder data input, MSB first, one bit per clk.
REQ-012 tx_active  output  1  high while state = RUN.
REQ-013 slot_owner  output  2  owner of the current tx_bit: 00 idle, 01 A, 10 B, 11 unused.
REQ-014 idle_cnt  output  IDLE_CNT_W  count of idle-filled slots, saturating.

Function
REQ-015 The block SHALL use two states, STOP and RUN, and a 3-bit bit counter bit_cnt.
REQ-016 Boundary cycle = (state = STOP and enable = 1) or (state = RUN and bit_cnt = 7).
REQ-017 In a boundary cycle with enable = 1: grant chosen, shift register loaded with the granted byte (or the idle byte if no valid), bit_cnt <= 0, state <= RUN.
REQ-018 In a boundary cycle with enable = 0: state <= STOP, no load, no ready.
REQ-019 In RUN outside a boundary cycle: shift register shifts left by one and bit_cnt increments.
REQ-020 tx_bit SHALL be registered shift-register MSB; a byte accepted in cycle t appears as bit7 at t+1 through bit0 at t+8, with no gap between consecutive slots.
REQ-021 In STOP, tx_bit = 0 and slot_owner = 00.
REQ-022 x_ready SHALL be combinational and high only in a boundary cycle with enable = 1 when requester x is granted; x_ready implies x_valid.
REQ-023 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last; neither -> idle fill.
REQ-024 last_grant SHALL update only on an actual A/B grant; idle slots leave it unchanged.
REQ-025 slot_owner SHALL be registered with the load and stay constant for all 8 bits of the slot.
REQ-026 idle_cnt increments by 1 on each idle-filled load and saturates at all-ones.
REQ-027 clr_idle_cnt clears idle_cnt; if it coincides with an idle load, the result is 1.
REQ-028 enable falling mid-slot SHALL NOT truncate the slot; the current byte completes, then STOP.
REQ-029 idle_sel is sampled only at load; a change mid-slot does not affect the current slot.

Reset
REQ-030 reset SHALL put state = STOP, bit_cnt = 7, shift register = 0, tx_bit = 0, tx_active = 0, slot_owner = 00, idle_cnt = 0, last_grant = B (so A wins the first tie).
REQ-031 reset SHALL override all other inputs in the same cycle, including mid-slot; a_ready = b_ready = 0 while reset = 1.

Structure
REQ-032 Shared package hdb3_pkg SHALL hold: slot-owner encodings, the idle byte constants 8'hFF/8'h00, and the STOP/RUN state encoding.
REQ-033 A 2-requester round-robin arbiter SHALL be a sub-module named rr_arb2 (inputs: two requests, last_grant, advance; outputs: one-hot grant).

Verification
REQ-034 Reset then enable = 1, no valids, idle_sel = 1 -> tx_bit all 1s from the cycle after enable, slot_owner = 00, idle_cnt = 1, 2, 3 every 8 clks.
REQ-035 a_valid held with a_data = 8'hA5, b idle -> a_ready pulses every 8 clks; tx_bit = 1,0,1,0,0,1,0,1 repeating; slot_owner = 01.
REQ-036 Both valid, a_data = 8'h0F, b_data = 8'hF0 -> slots alternate A, B, A, B, with A first after reset; no idle slot.
REQ-037 enable dropped at bit_cnt = 3 of an A slot -> remaining 4 bits still sent, then tx_bit = 0 and tx_active = 0; no ready at that boundary.
REQ-038 reset asserted mid-slot -> next cycle all outputs at reset values; idle_cnt saturation checked with IDLE_CNT_W = 3 (stays at 7), and clr_idle_cnt on an idle load gives 1.
